// File: rtl/disp_reg_access_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the dispatcher
// register core access port. One transaction at a time goes through
// IDLE -> ISSUE -> RESP. The completion, read data and timeout status
// go back to the requester that was granted.
module disp_reg_access_arbiter #(
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255,
    parameter int PostedWrite   = 1
) (
    input  logic                    iClock,
    input  logic                    iReset,

    input  logic                    iReq0_Valid,
    input  logic                    iReq0_Write,
    input  logic [AddressWidth-1:0] iReq0_Address,
    input  logic [DataWidth-1:0]    iReq0_Data,
    output logic                    oReq0_Ack,
    output logic [DataWidth-1:0]    oReq0_ReadData,
    output logic                    oReq0_Error,

    input  logic                    iReq1_Valid,
    input  logic                    iReq1_Write,
    input  logic [AddressWidth-1:0] iReq1_Address,
    input  logic [DataWidth-1:0]    iReq1_Data,
    output logic                    oReq1_Ack,
    output logic [DataWidth-1:0]    oReq1_ReadData,
    output logic                    oReq1_Error,

    output logic [AddressWidth-1:0] oCoreWriteAddress,
    output logic [DataWidth-1:0]    oCoreWriteData,
    output logic                    oCoreWriteValid,
    input  logic                    iCoreWriteAck,

    output logic [AddressWidth-1:0] oCoreReadAddress,
    output logic                    oCoreReadValid,
    input  logic [DataWidth-1:0]    iCoreReadData,
    input  logic                    iCoreReadAck
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                  state_reg;
    logic                    last_grant_reg;
    logic                    grant_reg;
    logic                    write_reg;
    logic [CntWidth-1:0]     cnt_reg;
    logic [1:0]              ack_reg;
    logic [1:0]              err_reg;
    logic [DataWidth-1:0]    rdata_reg [2];
    logic                    core_wvalid_reg;
    logic                    core_rvalid_reg;
    logic [AddressWidth-1:0] core_waddr_reg;
    logic [DataWidth-1:0]    core_wdata_reg;
    logic [AddressWidth-1:0] core_raddr_reg;

    // Requests gathered into arrays so the grant index can select fields
    logic [1:0]              req_valid;
    logic [1:0]              req_write;
    logic [AddressWidth-1:0] req_addr [2];
    logic [DataWidth-1:0]    req_data [2];

    assign req_valid   = {iReq1_Valid, iReq0_Valid};
    assign req_write   = {iReq1_Write, iReq0_Write};
    assign req_addr[0] = iReq0_Address;
    assign req_addr[1] = iReq1_Address;
    assign req_data[0] = iReq0_Data;
    assign req_data[1] = iReq1_Data;

    // A tie goes to the requester that did not win last time; a lone request always wins
    logic grant_any;
    logic grant_idx;
    assign grant_any = |req_valid;
    assign grant_idx = (&req_valid) ? ~last_grant_reg : req_valid[1];

    // Completion conditions while the core channel is being driven
    logic hit;
    logic posted_done;
    logic timed_out;
    assign hit         = write_reg ? iCoreWriteAck : iCoreReadAck;
    assign posted_done = write_reg && (PostedWrite != 0);
    assign timed_out   = (cnt_reg == CntLast);

    // Sequencer: grant in IDLE, drive the core in ISSUE, pulse the response in RESP
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            grant_reg       <= 1'b0;
            write_reg       <= 1'b0;
            cnt_reg         <= '0;
            ack_reg         <= '0;
            err_reg         <= '0;
            rdata_reg[0]    <= '0;
            rdata_reg[1]    <= '0;
            core_wvalid_reg <= 1'b0;
            core_rvalid_reg <= 1'b0;
            core_waddr_reg  <= '0;
            core_wdata_reg  <= '0;
            core_raddr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        grant_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        write_reg      <= req_write[grant_idx];
                        cnt_reg        <= '0;
                        state_reg      <= ISSUE;
                        if (req_write[grant_idx]) begin
                            core_wvalid_reg <= 1'b1;
                            core_waddr_reg  <= req_addr[grant_idx];
                            core_wdata_reg  <= req_data[grant_idx];
                        end else begin
                            core_rvalid_reg <= 1'b1;
                            core_raddr_reg  <= req_addr[grant_idx];
                        end
                    end
                end
                ISSUE: begin
                    if (hit || posted_done || timed_out) begin
                        state_reg            <= RESP;
                        core_wvalid_reg      <= 1'b0;
                        core_rvalid_reg      <= 1'b0;
                        core_waddr_reg       <= '0;
                        core_wdata_reg       <= '0;
                        core_raddr_reg       <= '0;
                        ack_reg[grant_reg]   <= 1'b1;
                        err_reg[grant_reg]   <= !(hit || posted_done);
                        rdata_reg[grant_reg] <= (!write_reg && hit) ? iCoreReadData : '0;
                    end else if (cnt_reg != CntMax) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    ack_reg      <= '0;
                    err_reg      <= '0;
                    rdata_reg[0] <= '0;
                    rdata_reg[1] <= '0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oReq0_Ack         = ack_reg[0];
    assign oReq0_Error       = err_reg[0];
    assign oReq0_ReadData    = rdata_reg[0];
    assign oReq1_Ack         = ack_reg[1];
    assign oReq1_Error       = err_reg[1];
    assign oReq1_ReadData    = rdata_reg[1];
    assign oCoreWriteValid   = core_wvalid_reg;
    assign oCoreWriteAddress = core_waddr_reg;
    assign oCoreWriteData    = core_wdata_reg;
    assign oCoreReadValid    = core_rvalid_reg;
    assign oCoreReadAddress  = core_raddr_reg;

endmodule
